alu_host_driver: RTL and testbench

Initiator for the serial ALU protocol. Accepts one operation request over a valid/ready port, serialises the operands onto the ALU's 8-bit `inbus` behind a one-cycle `BEGIN` pulse, waits for `END`, and collects the result bytes from `outbus`. It then returns a single 16-bit response with status flags. It sits between the register/command front-end and the `alu` core, replacing the hand-driven sequencing otherwise done by benches.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_watchdog.sv | 42 ++++
 rtl/alu_host_driver.sv | 184 ++++++++++++++++++
 tb/tb_alu_host_driver.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU host driver.
//   OP_*          : ALU op-code values carried on req_op / alu_op_code
//   state_e       : host driver FSM state encoding
//   result_bytes  : number of result bytes the ALU returns for an op (1 or 2)
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND0 = 3'd1,
        ST_SEND1 = 3'd2,
        ST_SEND2 = 3'd3,
        ST_WAIT  = 3'd4,
        ST_CAPT  = 3'd5,
        ST_RESP  = 3'd6
    } state_e;

    // add/sub produce a single modulo-256 byte; mul/div produce two bytes.
    function automatic logic [1:0] result_bytes(input logic [1:0] op);
        return ((op == OP_MUL) || (op == OP_DIV)) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/alu_watchdog.sv
// Cycle counter bounding how long the host waits for END from the ALU.
//   clk, reset  : clock, asynchronous active-low reset
//   clear_i     : force the count back to zero (held while not waiting)
//   en_i        : count one cycle
//   expired_o   : count has reached TIMEOUT_CYCLES-1
module alu_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturate at LAST so a late-observed expiry never wraps back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/alu_host_driver.sv
// Host-side initiator for the serial ALU protocol. Takes one request on a
// valid/ready port, serialises operands onto alu_inbus behind a one-cycle
// alu_begin pulse, waits for alu_end, collects 1 or 2 result bytes and
// returns a 16-bit response with timeout/divide-by-zero flags.
//   clk, reset                    : clock, asynchronous active-low reset
//   req_valid/req_ready           : request handshake (ready only in IDLE)
//   req_op, req_a, req_b          : operation and operands
//   rsp_valid/rsp_ready           : response handshake (held until accepted)
//   rsp_result, rsp_timeout,
//   rsp_divzero                   : response payload
//   alu_begin, alu_op_code,
//   alu_inbus                     : drive side of the ALU
//   alu_outbus, alu_end           : return side of the ALU
module alu_host_driver
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [7:0]  req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_timeout,
    output logic        rsp_divzero,
    output logic        alu_begin,
    output logic [1:0]  alu_op_code,
    output logic [7:0]  alu_inbus,
    input  logic [7:0]  alu_outbus,
    input  logic        alu_end
);

    state_e      state_q;
    logic [1:0]  op_q;
    logic [15:0] a_q;
    logic [7:0]  b_q;
    logic [7:0]  byte0_q;
    logic        divzero_q;

    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_result_q;
    logic        rsp_timeout_q;
    logic        rsp_divzero_q;
    logic        alu_begin_q;
    logic [1:0]  alu_op_code_q;
    logic [7:0]  alu_inbus_q;

    logic        wd_expired;

    // The counter is held at zero outside WAIT, so it reads 0 on the first
    // WAIT cycle and TIMEOUT_CYCLES-1 on the last one.
    alu_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q != ST_WAIT),
        .en_i      (state_q == ST_WAIT),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_ADD;
            a_q           <= '0;
            b_q           <= '0;
            byte0_q       <= '0;
            divzero_q     <= 1'b0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_divzero_q <= 1'b0;
            alu_begin_q   <= 1'b0;
            alu_op_code_q <= OP_ADD;
            alu_inbus_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // req_ready is registered, so it rises on the first edge
                    // after reset release and the accept uses that value.
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        op_q          <= req_op;
                        a_q           <= req_a;
                        b_q           <= req_b;
                        divzero_q     <= (req_op == OP_DIV) && (req_b == 8'h00);
                        req_ready_q   <= 1'b0;
                        alu_begin_q   <= 1'b1;
                        alu_op_code_q <= req_op;
                        alu_inbus_q   <= (req_op == OP_DIV) ? req_a[15:8] : req_a[7:0];
                        state_q       <= ST_SEND0;
                    end
                end

                ST_SEND0: begin
                    alu_begin_q <= 1'b0;
                    alu_inbus_q <= (op_q == OP_DIV) ? a_q[7:0] : b_q;
                    state_q     <= ST_SEND1;
                end

                ST_SEND1: begin
                    if (op_q == OP_DIV) begin
                        alu_inbus_q <= b_q;
                        state_q     <= ST_SEND2;
                    end else begin
                        alu_inbus_q <= '0;
                        state_q     <= ST_WAIT;
                    end
                end

                ST_SEND2: begin
                    alu_inbus_q <= '0;
                    state_q     <= ST_WAIT;
                end

                ST_WAIT: begin
                    // END wins over expiry when both land on the last cycle.
                    if (alu_end) begin
                        if (result_bytes(op_q) == 2'd2) begin
                            byte0_q <= alu_outbus;
                            state_q <= ST_CAPT;
                        end else begin
                            rsp_result_q  <= {8'h00, alu_outbus};
                            rsp_valid_q   <= 1'b1;
                            rsp_divzero_q <= divzero_q;
                            alu_op_code_q <= OP_ADD;
                            state_q       <= ST_RESP;
                        end
                    end else if (wd_expired) begin
                        rsp_result_q  <= '0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        rsp_divzero_q <= divzero_q;
                        alu_op_code_q <= OP_ADD;
                        state_q       <= ST_RESP;
                    end
                end

                ST_CAPT: begin
                    // Second byte follows END by exactly one cycle; END here
                    // is not looked at.
                    rsp_result_q  <= {byte0_q, alu_outbus};
                    rsp_valid_q   <= 1'b1;
                    rsp_divzero_q <= divzero_q;
                    alu_op_code_q <= OP_ADD;
                    state_q       <= ST_RESP;
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q   <= 1'b0;
                        rsp_result_q  <= '0;
                        rsp_timeout_q <= 1'b0;
                        rsp_divzero_q <= 1'b0;
                        req_ready_q   <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_divzero = rsp_divzero_q;
    assign alu_begin   = alu_begin_q;
    assign alu_op_code = alu_op_code_q;
    assign alu_inbus   = alu_inbus_q;

endmodule

// File: tb/tb_alu_host_driver.sv
module tb_alu_host_driver;

    localparam int TO = 64;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_a;
    logic [7:0]  req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_timeout;
    logic        rsp_divzero;
    logic        alu_begin;
    logic [1:0]  alu_op_code;
    logic [7:0]  alu_inbus;
    logic [7:0]  alu_outbus;
    logic        alu_end;

    int checks;
    int failures;

    // Per-cycle trace of the last transaction; index 1 is the cycle after accept.
    logic       tr_begin [0:255];
    logic [7:0] tr_inbus [0:255];
    logic [1:0] tr_op    [0:255];
    logic       tr_rdy   [0:255];

    alu_host_driver #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_timeout (rsp_timeout),
        .rsp_divzero (rsp_divzero),
        .alu_begin   (alu_begin),
        .alu_op_code (alu_op_code),
        .alu_inbus   (alu_inbus),
        .alu_outbus  (alu_outbus),
        .alu_end     (alu_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "bench timed out");
    end

    // ALU protocol model: the ALU sees operands, and END comes end_at cycles
    // after WAIT entry (end_at < 0: never). WAIT begins on cycle 3, or 4 for div.
    task automatic run_txn(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b,
                           input int end_at, input int end_len,
                           input logic [7:0] ob0, input logic [7:0] ob1,
                           input bit spurious, output int lat);
        int w;
        int n;
        w = (op == 2'b11) ? 4 : 3;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_a     = 16'($urandom);
        req_b     = 8'($urandom);
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            tr_begin[i] = alu_begin;
            tr_inbus[i] = alu_inbus;
            tr_op[i]    = alu_op_code;
            tr_rdy[i]   = req_ready;
            if (rsp_valid) begin
                lat = i;
                alu_end = 1'b0;
                break;
            end
            if (end_at >= 0 && i >= w + end_at && i < w + end_at + end_len) alu_end = 1'b1;
            else if (spurious && i == 1) alu_end = 1'b1;
            else alu_end = 1'b0;
            if (end_at >= 0 && i == w + end_at) alu_outbus = ob0;
            else if (end_at >= 0 && i == w + end_at + 1) alu_outbus = ob1;
            else alu_outbus = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_result, rsp_timeout, rsp_divzero, alu_begin, alu_op_code, alu_inbus} !== 31'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {req_ready, rsp_valid, rsp_result, rsp_timeout, rsp_divzero, alu_begin, alu_op_code, alu_inbus});
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b want=1", req_ready);
        end
    endtask

    task automatic test_add();
        int lat;
        int nb;
        run_txn(2'b00, 16'h003C, 8'h55, 3, 1, 8'((8'h3C + 8'h55)), 8'h00, 1'b0, lat);
        checks++;
        if (lat !== 7) begin failures++; $display("FAIL add_latency got=%0d want=7", lat); end
        checks++;
        if ({rsp_result, rsp_timeout, rsp_divzero} !== {16'h0091, 2'b00}) begin
            failures++;
            $display("FAIL add_result got=%h/%b%b want=0091/00", rsp_result, rsp_timeout, rsp_divzero);
        end
        nb = 0;
        for (int i = 1; i <= lat; i++) if (tr_begin[i] === 1'b1) nb++;
        checks++;
        if (nb != 1 || tr_begin[1] !== 1'b1) begin
            failures++;
            $display("FAIL add_begin_pulse got=%0d cycles (first=%b) want=1", nb, tr_begin[1]);
        end
        finish_rsp();
    endtask

    task automatic test_sub();
        int lat;
        run_txn(2'b01, 16'h0010, 8'h20, 0, 1, 8'(8'h10 - 8'h20), 8'h00, 1'b0, lat);
        checks++;
        if ({tr_inbus[1], tr_inbus[2], tr_inbus[3]} !== 24'h102000) begin
            failures++;
            $display("FAIL sub_inbus got=%h %h %h want=10 20 00", tr_inbus[1], tr_inbus[2], tr_inbus[3]);
        end
        checks++;
        if (lat !== 4 || rsp_result !== 16'h00F0) begin
            failures++;
            $display("FAIL sub_result got=%h lat=%0d want=00f0 lat=4", rsp_result, lat);
        end
        finish_rsp();
    endtask

    task automatic test_mul();
        int lat;
        logic [15:0] p;
        bit ok;
        p = 16'hFF * 16'hFF;
        // END held into CAPT too; it must not restart capture.
        run_txn(2'b10, 16'h00FF, 8'hFF, 0, 2, p[15:8], p[7:0], 1'b0, lat);
        checks++;
        if (lat !== 5 || rsp_result !== 16'hFE01) begin
            failures++;
            $display("FAIL mul_result got=%h lat=%0d want=fe01 lat=5", rsp_result, lat);
        end
        ok = 1'b1;
        for (int i = 1; i <= 4; i++) if (tr_op[i] !== 2'b10) ok = 1'b0;
        checks++;
        if (!ok || alu_op_code !== 2'b00) begin
            failures++;
            $display("FAIL mul_opcode got=%b%b%b%b resp=%b want=10x4 resp=00",
                     tr_op[1], tr_op[2], tr_op[3], tr_op[4], alu_op_code);
        end
        finish_rsp();
    endtask

    task automatic test_div();
        int lat;
        logic [15:0] q;
        logic [15:0] r;
        q = 16'h1234 / 16'h0056;
        r = 16'h1234 % 16'h0056;
        run_txn(2'b11, 16'h1234, 8'h56, 0, 1, q[7:0], r[7:0], 1'b1, lat);
        checks++;
        if ({tr_inbus[1], tr_inbus[2], tr_inbus[3], tr_inbus[4]} !== 32'h12345600) begin
            failures++;
            $display("FAIL div_inbus got=%h %h %h %h want=12 34 56 00",
                     tr_inbus[1], tr_inbus[2], tr_inbus[3], tr_inbus[4]);
        end
        checks++;
        if (lat !== 6 || rsp_result !== 16'h3610 || rsp_divzero !== 1'b0) begin
            failures++;
            $display("FAIL div_result got=%h lat=%0d dz=%b want=3610 lat=6 dz=0", rsp_result, lat, rsp_divzero);
        end
        finish_rsp();
    endtask

    task automatic test_div_timeout();
        int lat;
        run_txn(2'b11, 16'h1234, 8'h00, -1, 0, 8'h00, 8'h00, 1'b0, lat);
        checks++;
        if (lat !== 4 + TO) begin
            failures++;
            $display("FAIL timeout_latency got=%0d want=%0d", lat, 4 + TO);
        end
        checks++;
        if ({rsp_result, rsp_timeout, rsp_divzero} !== {16'h0000, 2'b11}) begin
            failures++;
            $display("FAIL timeout_flags got=%h/%b%b want=0000/11", rsp_result, rsp_timeout, rsp_divzero);
        end
        finish_rsp();
    endtask

    task automatic test_rsp_hold();
        int lat;
        logic [7:0] a;
        logic [7:0] b;
        logic [15:0] exp;
        bit ok;
        a = 8'($urandom);
        b = 8'($urandom);
        exp = {8'h00, 8'(a + b)};
        run_txn(2'b00, {8'($urandom), a}, b, 1, 1, 8'(a + b), 8'h00, 1'b0, lat);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_result !== exp || req_ready !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rsp_hold got vld=%b res=%h rdy=%b want vld=1 res=%h rdy=0", rsp_valid, rsp_result, req_ready, exp);
        end
        finish_rsp();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rsp_release got vld=%b rdy=%b want vld=0 rdy=1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_a     = 16'h0012;
        req_b     = 8'h34;
        @(negedge clk);
        req_valid = 1'b0;
        alu_end   = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_result, rsp_timeout, rsp_divzero, alu_begin, alu_op_code, alu_inbus} !== 31'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h want=0",
                     {req_ready, rsp_valid, rsp_result, rsp_timeout, rsp_divzero, alu_begin, alu_op_code, alu_inbus});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_txn(2'b10, 16'h0012, 8'h34, 2, 1, 8'h03, 8'hA8, 1'b0, lat);
        checks++;
        if (lat !== 7 || rsp_result !== 16'h03A8) begin
            failures++;
            $display("FAIL midreset_next got=%h lat=%0d want=03a8 lat=7", rsp_result, lat);
        end
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 30; t++) begin
            logic [1:0]  op;
            logic [15:0] a;
            logic [7:0]  b;
            logic [15:0] full;
            logic [7:0]  ob0;
            logic [7:0]  ob1;
            logic [15:0] exp;
            logic [7:0]  bytes [0:3];
            int end_at;
            int nbytes;
            int w;
            int lat;
            int exp_lat;
            bit to;
            bit dz;
            bit ok;
            op = 2'($urandom);
            b  = 8'($urandom);
            a  = 16'($urandom);
            if (op == 2'b11) begin
                if ($urandom_range(0, 7) == 0) b = 8'h00;
                if (b != 0) a = {8'($urandom_range(0, 32'(b) - 1)), 8'($urandom)};
            end
            end_at = $urandom_range(0, 5);
            dz = (op == 2'b11) && (b == 8'h00);
            case (op)
                2'b00: begin full = 16'(a[7:0] + b); ob0 = full[7:0]; ob1 = 8'h00; exp = {8'h00, ob0}; nbytes = 1; end
                2'b01: begin full = 16'(a[7:0] - b); ob0 = full[7:0]; ob1 = 8'h00; exp = {8'h00, ob0}; nbytes = 1; end
                2'b10: begin full = 16'(a[7:0]) * 16'(b); ob0 = full[15:8]; ob1 = full[7:0]; exp = full; nbytes = 2; end
                default: begin
                    if (dz) begin ob0 = 8'h00; ob1 = 8'h00; end
                    else begin ob0 = 8'(a / 16'(b)); ob1 = 8'(a % 16'(b)); end
                    exp = {ob0, ob1};
                    nbytes = 2;
                end
            endcase
            to = dz;
            if (to) begin end_at = -1; exp = 16'h0000; end
            w = (op == 2'b11) ? 4 : 3;
            exp_lat = to ? w + TO : w + end_at + nbytes;
            if (op == 2'b11) begin bytes[0] = a[15:8]; bytes[1] = a[7:0]; bytes[2] = b; bytes[3] = 8'h00; end
            else begin bytes[0] = a[7:0]; bytes[1] = b; bytes[2] = 8'h00; bytes[3] = 8'h00; end
            run_txn(op, a, b, end_at, 1, ob0, ob1, ($urandom_range(0, 1) == 1), lat);
            ok = 1'b1;
            for (int i = 0; i < w; i++) if (tr_inbus[i + 1] !== bytes[i]) ok = 1'b0;
            for (int i = 1; i < lat; i++) if (tr_rdy[i] !== 1'b0 || tr_begin[i] !== (i == 1)) ok = 1'b0;
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL rand_drive t=%0d op=%0d a=%h b=%h inbus=%h %h %h begin1=%b",
                         t, op, a, b, tr_inbus[1], tr_inbus[2], tr_inbus[3], tr_begin[1]);
            end
            checks++;
            if (lat != exp_lat || rsp_result !== exp || rsp_timeout !== to || rsp_divzero !== dz) begin
                failures++;
                $display("FAIL rand_rsp t=%0d op=%0d got=%h to=%b dz=%b lat=%0d want=%h to=%b dz=%b lat=%0d",
                         t, op, rsp_result, rsp_timeout, rsp_divzero, lat, exp, to, dz, exp_lat);
            end
            finish_rsp();
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = 16'h0000;
        req_b      = 8'h00;
        rsp_ready  = 1'b0;
        alu_outbus = 8'h00;
        alu_end    = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_div_timeout();
        test_rsp_hold();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
